// File: rtl/wavetable_loader.sv
// Host-driven write port for the wavetable RAM: synchronises the host strobe and
// issues one WE/WCLK write per strobe rising edge, auto-incrementing within a bank.
module wavetable_loader #(
    parameter int ADDRWIDTH = 8,
    parameter int DATAWIDTH = 16,
    parameter int BANKWIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 EXT_WRITE_ENABLE,
    input  logic                 EXT_WRITE,
    input  logic [DATAWIDTH-1:0] EXT_WDATA,
    input  logic [BANKWIDTH-1:0] EXT_BANK,
    output logic [ADDRWIDTH-1:0] WADDR,
    output logic [BANKWIDTH-1:0] wbank,
    output logic [DATAWIDTH-1:0] WDATA,
    output logic                 WE,
    output logic                 WCLK,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 OVERRUN
);

    // state   | meaning
    // IDLE    | waiting for a synchronised strobe rise
    // SETUP   | WE high, address/bank/data settling ahead of WCLK
    // STROBE  | WCLK high, RAM captures on this rising edge
    // RECOVER | WE/WCLK low, address advances on exit
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER
    } state_t;

    state_t state;
    state_t state_next;

    logic s1;
    logic s2;
    logic s3;
    logic en_d;
    logic rise;
    logic en_rise;
    logic start;
    logic drop;
    logic we_next;
    logic wclk_next;

    assign rise    = s2 & ~s3;
    assign en_rise = EXT_WRITE_ENABLE & ~en_d;

    // An enable rise on the same edge clears DONE, so the write is allowed and lands at address 0.
    assign start = (state == IDLE) & rise & EXT_WRITE_ENABLE & (en_rise | ~DONE);
    assign drop  = rise & EXT_WRITE_ENABLE & ((state != IDLE) | (DONE & ~en_rise));

    always_comb begin
        state_next = state;
        we_next    = WE;
        wclk_next  = WCLK;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SETUP;
                    we_next    = 1'b1;
                end
            end
            SETUP: begin
                state_next = STROBE;
                wclk_next  = 1'b1;
            end
            STROBE: begin
                state_next = RECOVER;
                wclk_next  = 1'b0;
                we_next    = 1'b0;
            end
            RECOVER: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                wclk_next  = 1'b0;
                we_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            WE    <= 1'b0;
            WCLK  <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_next;
            WE    <= we_next;
            WCLK  <= wclk_next;
            BUSY  <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            en_d <= 1'b0;
        end else begin
            s1   <= EXT_WRITE;
            s2   <= s1;
            s3   <= s2;
            en_d <= EXT_WRITE_ENABLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            WDATA <= '0;
        end else if (start) begin
            WDATA <= EXT_WDATA;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            WADDR <= '0;
            wbank <= '0;
            DONE  <= 1'b0;
        end else if (en_rise) begin
            WADDR <= '0;
            wbank <= EXT_BANK;
            DONE  <= 1'b0;
        end else if (state == RECOVER) begin
            WADDR <= WADDR + ADDRWIDTH'(1);
            if (&WADDR) begin
                DONE <= 1'b1;
            end
        end
    end

    // A dropped strobe coinciding with an enable rise still reports, so set wins over clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            OVERRUN <= 1'b0;
        end else if (drop) begin
            OVERRUN <= 1'b1;
        end else if (en_rise) begin
            OVERRUN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wavetable_loader.sv
// Directed bench for wavetable_loader: cycle-exact vector table for one write,
// a write-record table, and hand sequences for full table, overrun, enable drop and reset.
module tb_wavetable_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EXT_WRITE_ENABLE;
    logic        EXT_WRITE;
    logic [15:0] EXT_WDATA;
    logic [1:0]  EXT_BANK;
    logic [7:0]  WADDR;
    logic [1:0]  wbank;
    logic [15:0] WDATA;
    logic        WE;
    logic        WCLK;
    logic        BUSY;
    logic        DONE;
    logic        OVERRUN;

    int checks = 0;
    int errors = 0;
    int wclk_count = 0;
    int c0;
    logic [7:0]  cap_addr = '0;
    logic [1:0]  cap_bank = '0;
    logic [15:0] cap_data = '0;

    typedef struct {
        logic       ext_write;
        logic       exp_we;
        logic       exp_wclk;
        logic       exp_busy;
        logic [7:0] exp_waddr;
    } cyc_vec_t;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  exp_addr;
        logic [1:0]  exp_bank;
    } wr_vec_t;

    cyc_vec_t cyc_tbl[7];
    wr_vec_t  wr_tbl[3];

    wavetable_loader #(
        .ADDRWIDTH(8),
        .DATAWIDTH(16),
        .BANKWIDTH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .EXT_WRITE_ENABLE(EXT_WRITE_ENABLE),
        .EXT_WRITE(EXT_WRITE),
        .EXT_WDATA(EXT_WDATA),
        .EXT_BANK(EXT_BANK),
        .WADDR(WADDR),
        .wbank(wbank),
        .WDATA(WDATA),
        .WE(WE),
        .WCLK(WCLK),
        .BUSY(BUSY),
        .DONE(DONE),
        .OVERRUN(OVERRUN)
    );

    always #5 clk = ~clk;

    // RAM-side view: what would be captured on each WCLK rise.
    always @(posedge WCLK) begin
        wclk_count = wclk_count + 1;
        cap_addr   = WADDR;
        cap_bank   = wbank;
        cap_data   = WDATA;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] data);
        EXT_WDATA = data;
        EXT_WRITE = 1'b1;
        repeat (4) tick();
        EXT_WRITE = 1'b0;
        repeat (4) tick();
    endtask

    task automatic reenable(input logic [1:0] bank);
        EXT_WRITE_ENABLE = 1'b0;
        tick();
        EXT_BANK = bank;
        EXT_WRITE_ENABLE = 1'b1;
        tick();
    endtask

    initial begin
        cyc_tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        cyc_tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        cyc_tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        cyc_tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
        cyc_tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        cyc_tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        cyc_tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};

        wr_tbl[0] = '{16'd1, 8'd0, 2'd2};
        wr_tbl[1] = '{16'd2, 8'd1, 2'd2};
        wr_tbl[2] = '{16'd3, 8'd2, 2'd2};

        rst_n            = 1'b0;
        EXT_WRITE_ENABLE = 1'b0;
        EXT_WRITE        = 1'b0;
        EXT_WDATA        = 16'h1234;
        EXT_BANK         = 2'd3;
        repeat (3) tick();
        chk("rst_waddr", 32'(WADDR), 32'd0);
        chk("rst_wbank", 32'(wbank), 32'd0);
        chk("rst_wdata", 32'(WDATA), 32'd0);
        chk("rst_we", 32'(WE), 32'd0);
        chk("rst_wclk", 32'(WCLK), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_overrun", 32'(OVERRUN), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single write, checked cycle by cycle.
        EXT_BANK         = 2'd2;
        EXT_WDATA        = 16'hA5A5;
        EXT_WRITE_ENABLE = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            EXT_WRITE = cyc_tbl[i].ext_write;
            tick();
            chk($sformatf("t1_we_c%0d", i), 32'(WE), 32'(cyc_tbl[i].exp_we));
            chk($sformatf("t1_wclk_c%0d", i), 32'(WCLK), 32'(cyc_tbl[i].exp_wclk));
            chk($sformatf("t1_busy_c%0d", i), 32'(BUSY), 32'(cyc_tbl[i].exp_busy));
            chk($sformatf("t1_waddr_c%0d", i), 32'(WADDR), 32'(cyc_tbl[i].exp_waddr));
            if (cyc_tbl[i].exp_wclk) begin
                chk("t1_wbank_pulse", 32'(wbank), 32'd2);
                chk("t1_wdata_pulse", 32'(WDATA), 32'hA5A5);
            end
        end
        chk("t1_wclk_count", 32'(wclk_count), 32'd1);
        chk("t1_cap_addr", 32'(cap_addr), 32'd0);

        // Three spaced writes from a fresh enable.
        reenable(2'd2);
        for (int i = 0; i < 3; i++) begin
            c0 = wclk_count;
            do_write(wr_tbl[i].data);
            chk($sformatf("t2_pulses_w%0d", i), 32'(wclk_count - c0), 32'd1);
            chk($sformatf("t2_addr_w%0d", i), 32'(cap_addr), 32'(wr_tbl[i].exp_addr));
            chk($sformatf("t2_bank_w%0d", i), 32'(cap_bank), 32'(wr_tbl[i].exp_bank));
            chk($sformatf("t2_data_w%0d", i), 32'(cap_data), 32'(wr_tbl[i].data));
        end
        chk("t2_final_waddr", 32'(WADDR), 32'd3);
        chk("t2_overrun", 32'(OVERRUN), 32'd0);

        // Fill a whole bank, then one strobe too many.
        reenable(2'd1);
        chk("t3_waddr_start", 32'(WADDR), 32'd0);
        c0 = wclk_count;
        for (int i = 0; i < 255; i++) begin
            do_write(16'(i + 16'h100));
        end
        chk("t3_done_at_255", 32'(DONE), 32'd0);
        chk("t3_waddr_at_255", 32'(WADDR), 32'd255);
        do_write(16'hFFEE);
        chk("t3_pulses_256", 32'(wclk_count - c0), 32'd256);
        chk("t3_last_addr", 32'(cap_addr), 32'd255);
        chk("t3_last_bank", 32'(cap_bank), 32'd1);
        chk("t3_last_data", 32'(cap_data), 32'hFFEE);
        chk("t3_done", 32'(DONE), 32'd1);
        chk("t3_waddr_wrap", 32'(WADDR), 32'd0);
        chk("t3_overrun_before", 32'(OVERRUN), 32'd0);
        do_write(16'h0BAD);
        chk("t3_pulses_257", 32'(wclk_count - c0), 32'd256);
        chk("t3_overrun_after", 32'(OVERRUN), 32'd1);
        chk("t3_wdata_held", 32'(WDATA), 32'hFFEE);

        // Re-enable clears status; then a second rise while busy is dropped.
        reenable(2'd3);
        chk("t4_clr_overrun", 32'(OVERRUN), 32'd0);
        chk("t4_clr_done", 32'(DONE), 32'd0);
        chk("t4_clr_waddr", 32'(WADDR), 32'd0);
        chk("t4_bank", 32'(wbank), 32'd3);
        EXT_WDATA = 16'hBEEF;
        c0 = wclk_count;
        EXT_WRITE = 1'b1;
        tick();
        EXT_WRITE = 1'b0;
        tick();
        EXT_WRITE = 1'b1;
        tick();
        chk("t4_busy_setup", 32'(BUSY), 32'd1);
        chk("t4_overrun_early", 32'(OVERRUN), 32'd0);
        tick();
        tick();
        chk("t4_overrun_set", 32'(OVERRUN), 32'd1);
        EXT_WRITE = 1'b0;
        repeat (6) tick();
        chk("t4_pulses", 32'(wclk_count - c0), 32'd1);
        chk("t4_cap_data", 32'(cap_data), 32'hBEEF);
        chk("t4_waddr", 32'(WADDR), 32'd1);
        reenable(2'd3);
        chk("t4_reen_overrun", 32'(OVERRUN), 32'd0);
        chk("t4_reen_done", 32'(DONE), 32'd0);
        chk("t4_reen_waddr", 32'(WADDR), 32'd0);

        // Enable drops while WCLK is high; the write still completes.
        EXT_WDATA = 16'h5555;
        c0 = wclk_count;
        EXT_WRITE = 1'b1;
        repeat (4) tick();
        chk("t5_wclk_high", 32'(WCLK), 32'd1);
        EXT_WRITE = 1'b0;
        EXT_WRITE_ENABLE = 1'b0;
        tick();
        chk("t5_recover_wclk", 32'(WCLK), 32'd0);
        chk("t5_recover_busy", 32'(BUSY), 32'd1);
        tick();
        chk("t5_idle_busy", 32'(BUSY), 32'd0);
        chk("t5_waddr_inc", 32'(WADDR), 32'd1);
        chk("t5_pulses", 32'(wclk_count - c0), 32'd1);
        do_write(16'h7777);
        chk("t5_no_write", 32'(wclk_count - c0), 32'd1);
        chk("t5_no_overrun", 32'(OVERRUN), 32'd0);
        chk("t5_waddr_held", 32'(WADDR), 32'd1);
        chk("t5_wdata_held", 32'(WDATA), 32'h5555);

        // Reset while WCLK is high aborts cleanly.
        EXT_BANK = 2'd1;
        EXT_WRITE_ENABLE = 1'b1;
        tick();
        tick();
        EXT_WDATA = 16'h3C3C;
        c0 = wclk_count;
        EXT_WRITE = 1'b1;
        repeat (4) tick();
        chk("t6_wclk_high", 32'(WCLK), 32'd1);
        EXT_WRITE = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("t6_rst_wclk", 32'(WCLK), 32'd0);
        chk("t6_rst_we", 32'(WE), 32'd0);
        chk("t6_rst_waddr", 32'(WADDR), 32'd0);
        chk("t6_rst_busy", 32'(BUSY), 32'd0);
        rst_n = 1'b1;
        repeat (8) tick();
        chk("t6_no_spurious", 32'(wclk_count - c0), 32'd1);
        chk("t6_idle_busy", 32'(BUSY), 32'd0);
        chk("t6_idle_we", 32'(WE), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
